// File: rtl/fb_pkg.sv
// Shared definitions for the camera-to-VGA double-buffered framebuffer path.
package fb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_HOLD    = 2'd2
   } fb_state_t;

   localparam int QQVGA_H            = 160;
   localparam int QQVGA_V            = 120;
   localparam int QQVGA_FRAME_PIXELS = QQVGA_H * QQVGA_V;
   localparam int DEFAULT_ADDR_WIDTH = 15;

endpackage

// File: rtl/fb_write_addr_gen.sv
// Per-frame pixel counter feeding the registered back-bank write port.
module fb_write_addr_gen
   import fb_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int FRAME_PIXELS = QQVGA_FRAME_PIXELS
) (
   input  logic                  clk_25,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  capture_en,
   input  logic                  pixel_valid,
   input  logic                  bank,
   output logic [ADDR_WIDTH-1:0] pix_cnt,
   output logic                  overflow,
   output logic                  we,
   output logic [ADDR_WIDTH:0]   write_addr
);

   localparam logic [ADDR_WIDTH-1:0] FRAME_CNT = ADDR_WIDTH'(FRAME_PIXELS);

   // Count stops at FRAME_CNT; surplus strobes only mark the frame as overlong.
   always_ff @(posedge clk_25) begin
      if (reset) begin
         pix_cnt    <= '0;
         overflow   <= 1'b0;
         we         <= 1'b0;
         write_addr <= '0;
      end else begin
         we <= 1'b0;
         if (clear) begin
            pix_cnt  <= '0;
            overflow <= 1'b0;
         end else if (capture_en && pixel_valid) begin
            if (pix_cnt < FRAME_CNT) begin
               we         <= 1'b1;
               write_addr <= {bank, pix_cnt};
               pix_cnt    <= pix_cnt + 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fb_bank_ctrl.sv
// Double-buffer bank scheduler: captures into the back bank, swaps only in VGA vblank.
module fb_bank_ctrl
   import fb_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
   parameter int FRAME_PIXELS   = QQVGA_FRAME_PIXELS,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                      clk_25,
   input  logic                      reset,
   input  logic                      cam_frame_start,
   input  logic                      cam_frame_done,
   input  logic                      cam_pixel_valid,
   input  logic                      vga_frame_start,
   input  logic [ADDR_WIDTH-1:0]     vga_pixel_addr,
   output logic [ADDR_WIDTH:0]       read_addr,
   output logic [ADDR_WIDTH:0]       write_addr,
   output logic                      we,
   output logic                      front_bank,
   output logic                      display_valid,
   output logic                      frame_pending,
   output logic                      frame_error,
   output logic [DROP_CNT_WIDTH-1:0] drop_count
);

   localparam logic [ADDR_WIDTH-1:0] FRAME_CNT = ADDR_WIDTH'(FRAME_PIXELS);

   fb_state_t             state, state_next;
   logic [ADDR_WIDTH-1:0] pix_cnt;
   logic                  overflow;
   logic                  swap, pending_eff;
   logic                  cnt_clear, capture_en, frame_ok, frame_bad, drop_evt;

   // A swap in the same edge frees the pending slot, so a coinciding start captures.
   assign swap        = vga_frame_start & frame_pending;
   assign pending_eff = frame_pending & ~swap;
   assign read_addr   = {front_bank, vga_pixel_addr};

   always_ff @(posedge clk_25) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (cam_frame_start) state_next = pending_eff ? ST_HOLD : ST_CAPTURE;
         ST_CAPTURE: if (cam_frame_start) state_next = ST_CAPTURE;
                     else if (cam_frame_done) state_next = ST_IDLE;
         ST_HOLD:    if (cam_frame_done) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_clear  = 1'b0;
      capture_en = 1'b0;
      frame_ok   = 1'b0;
      frame_bad  = 1'b0;
      drop_evt   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clear = cam_frame_start & ~pending_eff;
            drop_evt  = cam_frame_start & pending_eff;
         end
         ST_CAPTURE: begin
            if (cam_frame_start) begin
               cnt_clear = 1'b1;
               frame_bad = 1'b1;
            end else if (cam_frame_done) begin
               frame_ok  = (pix_cnt == FRAME_CNT) && !overflow;
               frame_bad = !((pix_cnt == FRAME_CNT) && !overflow);
            end else begin
               capture_en = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_25) begin
      if (reset) begin
         front_bank    <= 1'b0;
         display_valid <= 1'b0;
         frame_pending <= 1'b0;
         frame_error   <= 1'b0;
         drop_count    <= '0;
      end else begin
         frame_error   <= frame_bad;
         frame_pending <= pending_eff | frame_ok;
         if (swap) begin
            front_bank    <= ~front_bank;
            display_valid <= 1'b1;
         end
         if (drop_evt && drop_count != {DROP_CNT_WIDTH{1'b1}})
            drop_count <= drop_count + 1'b1;
      end
   end

   fb_write_addr_gen #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .FRAME_PIXELS (FRAME_PIXELS)
   ) u_write_addr_gen (
      .clk_25      (clk_25),
      .reset       (reset),
      .clear       (cnt_clear),
      .capture_en  (capture_en),
      .pixel_valid (cam_pixel_valid),
      .bank        (~front_bank),
      .pix_cnt     (pix_cnt),
      .overflow    (overflow),
      .we          (we),
      .write_addr  (write_addr)
   );

endmodule

// File: doc/fb_bank_ctrl.md
Name: fb_bank_ctrl

Overview:
- Double-buffer scheduler for the camera-to-VGA framebuffer path. It owns the bank-select bit of a 2x-depth dual-port framebuffer.
- Generates the camera write address and write enable into the back bank. Steers VGA reads to the front bank.
- Swaps banks only during VGA vertical blanking, so the display never tears.
- Runs entirely in the clk_25 domain. Camera strobes arrive here already synchronized to clk_25.

Parameters:
- ADDR_WIDTH, 15: per-bank pixel address width (QQVGA 160x120 fits in 2^15).
- FRAME_PIXELS, 19200: exact pixel count of a valid camera frame.
- DROP_CNT_WIDTH, 8: width of the saturating dropped-frame counter.

Ports:
- clk_25  in  1  system pixel clock.
- reset  in  1  synchronous reset, active-high.
- cam_frame_start  in  1  one-cycle pulse at camera frame start (v_sync falling edge, synchronized).
- cam_frame_done  in  1  one-cycle pulse at camera frame end (v_sync rising edge, synchronized).
- cam_pixel_valid  in  1  one-cycle strobe, one per captured pixel.
- vga_frame_start  in  1  one-cycle pulse at start of VGA vertical blanking.
- vga_pixel_addr  in  ADDR_WIDTH  read address from the image generator.
- read_addr  out  ADDR_WIDTH+1  {front_bank, vga_pixel_addr}, combinational.
- write_addr  out  ADDR_WIDTH+1  {back_bank, pix_cnt}, registered.
- we  out  1  framebuffer write enable, registered.
- front_bank  out  1  bank currently displayed.
- display_valid  out  1  front bank holds a complete frame.
- frame_pending  out  1  a complete frame is waiting for a swap.
- frame_error  out  1  one-cycle pulse on a short or overlong frame.
- drop_count  out  DROP_CNT_WIDTH  frames skipped because a swap was pending; saturating.

Behaviour:
- Reset values: front_bank=0, back bank=1, we=0, write_addr=0, pix_cnt=0, display_valid=0, frame_pending=0, frame_error=0, drop_count=0, state=IDLE.
- Write FSM states: IDLE, CAPTURE, HOLD.
- IDLE:
  - cam_frame_start with frame_pending=0 -> CAPTURE, pix_cnt=0.
  - cam_frame_start with frame_pending=1 -> HOLD, drop_count+1 (saturating).
- CAPTURE:
  - On each cam_pixel_valid with pix_cnt<FRAME_PIXELS: next cycle we=1, write_addr={back_bank,pix_cnt}, then pix_cnt+1. Latency is 1 cycle, so the parent delays pixel data by 1 cycle.
  - pix_cnt is ADDR_WIDTH wide and saturates at FRAME_PIXELS. Strobes beyond that produce no write and set an internal overflow flag.
  - cam_frame_done with pix_cnt==FRAME_PIXELS and no overflow -> frame_pending=1, go to IDLE.
  - cam_frame_done with any other count or overflow -> frame_error pulse, frame_pending unchanged, go to IDLE. The back bank is reused for the next frame.
  - cam_frame_start while in CAPTURE (missed done) -> frame_error pulse, restart CAPTURE with pix_cnt=0.
- HOLD:
  - Ignores pixels, we=0.
  - cam_frame_done -> IDLE.
- Swap:
  - On vga_frame_start with frame_pending=1: front_bank toggles (back bank toggles with it), frame_pending=0, display_valid=1, all in the same edge.
  - vga_frame_start with frame_pending=0: no change.
- Simultaneous events:
  - cam_frame_done and vga_frame_start in the same cycle: the swap uses the registered frame_pending (old value). The newly completed frame swaps at the next vga_frame_start.
  - Swap and cam_frame_start in the same cycle in IDLE: the swap is applied first. The capture enters CAPTURE (not HOLD) into the new back bank and is not counted as a drop.
- Invariant: the write bank never equals front_bank while we=1.
- reset asserted mid-frame aborts capture (we=0 next cycle) and returns to reset values. display_valid=0 so the display can blank until the first swap.

Decomposition:
- Package fb_pkg holds:
  - FSM state encoding (IDLE/CAPTURE/HOLD);
  - the QQVGA constants FRAME_PIXELS=19200, H=160, V=120;
  - the ADDR_WIDTH default.
- One sub-module, fb_write_addr_gen: pix_cnt counter with saturation, overflow flag and the registered we/write_addr stage.
- The bank/swap logic and FSM stay in the top.

Test Plan:
- Normal frame: reset, cam_frame_start, 19200 cam_pixel_valid, cam_frame_done, then vga_frame_start -> write_addr runs {1,0}..{1,19199} with we=1 one cycle after each strobe; frame_pending=1; after the swap front_bank=1, display_valid=1, frame_pending=0.
- Short frame: 19199 pixels then done -> frame_error pulses once, frame_pending=0; the next vga_frame_start leaves front_bank=0.
- Overlong frame: 19210 strobes -> exactly 19200 writes, no write_addr beyond {1,19199}; frame_error on done.
- Drop: with frame_pending=1, a second cam_frame_start -> HOLD, we stays 0 for the whole frame, drop_count=1; 300 drops -> drop_count saturates at 255.
- Simultaneous: cam_frame_done and vga_frame_start in the same cycle -> no swap that cycle; swap occurs at the next vga_frame_start.
- Same-cycle swap/start: swap coincides with cam_frame_start -> capture writes to the new back bank. Separately, reset at pixel 5000 -> we=0 next cycle, front_bank=0, display_valid=0.
